cmp_chain_accum: RTL and testbench

- Sequential stage directly downstream of the 8-bit comparator (eq/gt/lt per byte pair).
- Consumes a stream of per-byte compare flags, most-significant byte first, and reduces them into one compare result for an operand up to MAX_BYTES bytes wide.
- Handshaked in and out with valid/ready, so the ALU can compare 16/32/64-bit unsigned operands over several cycles with one 8-bit comparator.

---
 rtl/cmp_chain_accum.sv | 136 +++++++++++++
 tb/tb_cmp_chain_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_chain_accum.sv
// ============================================================================
// Module      : cmp_chain_accum
// Description : Folds MS-byte-first eq/gt/lt comparator flags into one
//               multi-byte unsigned compare result, valid/ready on both sides.
//               Optional flag one-hot check enabled by CMP_CHAIN_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_chain_accum #(
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [CNT_W-1:0] out_bytes,
  output logic             out_trunc,
  output logic             err
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_accum = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [CNT_W-1:0] c_max_beats = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic [1:0]       r_state;
  logic [2:0]       r_acc;
  logic             r_decided;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_out_flags;
  logic [CNT_W-1:0] r_out_bytes;
  logic             r_out_trunc;

  logic [2:0]       w_flags;
  logic             w_accept;
  logic             w_start;
  logic             w_take;
  logic [2:0]       w_acc_next;
  logic             w_dec_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done;

  assign w_flags  = {eq_in, gt_in, lt_in};
  assign in_ready = (r_state != c_st_done);
  assign w_accept = in_valid && in_ready;
  // Any beat arriving in IDLE opens a new operand regardless of in_first.
  assign w_start  = (r_state == c_st_idle) || in_first;

  // Once a non-equal byte has been seen, lower bytes can no longer change it.
  assign w_take     = w_start || !r_decided;
  assign w_acc_next = w_take ? w_flags : r_acc;
  assign w_dec_next = w_take ? !eq_in : 1'b1;
  assign w_cnt_next = w_start ? c_one :
                      (r_count >= c_max_beats) ? c_max_beats : r_count + c_one;
  assign w_done     = in_last || (w_cnt_next == c_max_beats);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_acc       <= 3'b000;
      r_decided   <= 1'b0;
      r_count     <= '0;
      r_out_flags <= 3'b000;
      r_out_bytes <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_accum: begin
          if (w_accept) begin
            r_acc     <= w_acc_next;
            r_decided <= w_dec_next;
            r_count   <= w_cnt_next;
            if (w_done) begin
              r_state     <= c_st_done;
              r_out_flags <= w_acc_next;
              r_out_bytes <= w_cnt_next;
              r_out_trunc <= !in_last;
            end else begin
              r_state <= c_st_accum;
            end
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign out_valid = (r_state == c_st_done);
  assign out_eq    = r_out_flags[2];
  assign out_gt    = r_out_flags[1];
  assign out_lt    = r_out_flags[0];
  assign out_bytes = r_out_bytes;
  assign out_trunc = r_out_trunc;

`ifdef CMP_CHAIN_ERR_CHECK_EN
  logic r_err;
  logic w_bad;

  assign w_bad = !(w_flags inside {3'b100, 3'b010, 3'b001});

  // Sticky across the operand; restarted by each new operand's first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_start ? w_bad : (r_err | w_bad);
    end
  end

  assign err = r_err && out_valid;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmp_chain_accum.sv
// ============================================================================
// Module      : tb_cmp_chain_accum
// Description : Directed self-checking bench for cmp_chain_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_chain_accum;

  localparam int MAX_BYTES = 8;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic             eq_in;
  logic             gt_in;
  logic             lt_in;
  logic             out_valid;
  logic             out_ready;
  logic             out_eq;
  logic             out_gt;
  logic             out_lt;
  logic [CNT_W-1:0] out_bytes;
  logic             out_trunc;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_chain_accum #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .eq_in     (eq_in),
    .gt_in     (gt_in),
    .lt_in     (lt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_gt    (out_gt),
    .out_lt    (out_lt),
    .out_bytes (out_bytes),
    .out_trunc (out_trunc),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l, input logic [2:0] fl);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    {eq_in, gt_in, lt_in} = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [2:0] fl,
                            input int nb, input logic tr);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_flags"}, 32'({out_eq, out_gt, out_lt}), 32'(fl));
    chk({tag, "_bytes"}, 32'(out_bytes), 32'(nb));
    chk({tag, "_trunc"}, 32'(out_trunc), 32'(tr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    eq_in = 1'b0; gt_in = 1'b0; lt_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'({out_eq, out_gt, out_lt}), 32'd0);
    chk("rst_bytes", 32'(out_bytes), 32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2 beats: eq then gt -> gt
    beat(1'b1, 1'b0, 3'b100);
    chk("t1_mid_valid", 32'(out_valid), 32'd0);
    beat(1'b0, 1'b1, 3'b010);
    chk_result("t1", 3'b010, 2, 1'b0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    release_result();
    chk("t1_rel_valid", 32'(out_valid), 32'd0);
    chk("t1_rel_ready", 32'(in_ready), 32'd1);
    chk("t1_rel_hold", 32'({out_eq, out_gt, out_lt}), 32'b010);

    // 4 beats: lt decides, later bytes ignored
    beat(1'b1, 1'b0, 3'b001);
    beat(1'b0, 1'b0, 3'b010);
    beat(1'b0, 1'b0, 3'b100);
    beat(1'b0, 1'b1, 3'b010);
    chk_result("t2", 3'b001, 4, 1'b0);
    release_result();

    // 8 eq beats without in_last -> truncated at MAX_BYTES
    beat(1'b1, 1'b0, 3'b100);
    for (int i = 0; i < 6; i++) beat(1'b0, 1'b0, 3'b100);
    chk("t3_before_max", 32'(out_valid), 32'd0);
    beat(1'b0, 1'b0, 3'b100);
    chk_result("t3", 3'b100, 8, 1'b1);
    release_result();

    // backpressure: pending beat must not be taken while DONE
    beat(1'b1, 1'b1, 3'b010);
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    {eq_in, gt_in, lt_in} = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_flags", 32'({out_eq, out_gt, out_lt}), 32'b010);
      chk("t4_stall_bytes", 32'(out_bytes), 32'd1);
      chk("t4_stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    chk("t4_idle_ready", 32'(in_ready), 32'd1);
    beat(1'b1, 1'b1, 3'b001);
    chk_result("t4_next", 3'b001, 1, 1'b0);
    release_result();

    // restart with in_first mid-operand
    beat(1'b1, 1'b0, 3'b001);
    beat(1'b0, 1'b0, 3'b100);
    beat(1'b1, 1'b0, 3'b100);
    beat(1'b0, 1'b1, 3'b010);
    chk_result("t5_restart", 3'b010, 2, 1'b0);
    release_result();

    // reset mid-operand; next beat is first even without in_first
    beat(1'b1, 1'b0, 3'b001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    beat(1'b0, 1'b1, 3'b010);
    chk_result("t6_after", 3'b010, 1, 1'b0);
    release_result();

    // idle gaps in ACCUM hold state
    beat(1'b1, 1'b0, 3'b100);
    repeat (3) @(posedge clk);
    #1;
    chk("t7_gap_valid", 32'(out_valid), 32'd0);
    beat(1'b0, 1'b1, 3'b001);
    chk_result("t7", 3'b001, 2, 1'b0);
    release_result();

    // integrity flag
    beat(1'b1, 1'b1, 3'b110);
`ifdef CMP_CHAIN_ERR_CHECK_EN
    chk("t8_err_set", 32'(err), 32'd1);
`else
    chk("t8_err_off", 32'(err), 32'd0);
`endif
    release_result();
    chk("t8_err_idle", 32'(err), 32'd0);
    beat(1'b1, 1'b1, 3'b100);
    chk("t8_err_clean", 32'(err), 32'd0);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
